// File: rtl/reg_arb_pkg.sv
// Shared sizes and helpers for the register write-back arbiter slice.
package reg_arb_pkg;
   localparam int NUM_REGS   = 8;
   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 16;
   localparam int AGE_W      = 4;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_A    = 2'd1,
      GRANT_B    = 2'd2
   } grant_e;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      return NUM_REGS'(1) << addr;
   endfunction
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Write-back request, issue/decode and register-file signals of the arbiter.
interface reg_write_arbiter_if;
   import reg_arb_pkg::*;

   logic                  A_Valid;
   logic [REG_ADDR_W-1:0] A_RD;
   logic [DATA_W-1:0]     A_Data;
   logic                  A_Ready;
   logic                  B_Valid;
   logic [REG_ADDR_W-1:0] B_RD;
   logic [DATA_W-1:0]     B_Data;
   logic                  B_Ready;
   logic                  Issue_Valid;
   logic [REG_ADDR_W-1:0] Issue_RD;
   logic [REG_ADDR_W-1:0] Src_RS;
   logic [REG_ADDR_W-1:0] Src_RT;
   logic                  RegWrite;
   logic [REG_ADDR_W-1:0] RD;
   logic [DATA_W-1:0]     WriteData;
   logic                  Hazard;
   logic                  Busy;

   modport master (
      output A_Valid, A_RD, A_Data, B_Valid, B_RD, B_Data,
             Issue_Valid, Issue_RD, Src_RS, Src_RT,
      input  A_Ready, B_Ready, RegWrite, RD, WriteData, Hazard, Busy
   );

   modport slave (
      input  A_Valid, A_RD, A_Data, B_Valid, B_RD, B_Data,
             Issue_Valid, Issue_RD, Src_RS, Src_RT,
      output A_Ready, B_Ready, RegWrite, RD, WriteData, Hazard, Busy
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at commit.
module reg_scoreboard
   import reg_arb_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_set_vld,
   input  logic [REG_ADDR_W-1:0] i_set_rd,
   input  logic                  i_clr_vld,
   input  logic [REG_ADDR_W-1:0] i_clr_rd,
   input  logic [REG_ADDR_W-1:0] i_src_rs,
   input  logic [REG_ADDR_W-1:0] i_src_rt,
   output logic [NUM_REGS-1:0]   o_pending,
   output logic                  o_hazard
);
   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;

   always_comb begin
      w_set = i_set_vld ? reg_onehot(i_set_rd) : '0;
      w_clr = i_clr_vld ? reg_onehot(i_clr_rd) : '0;
   end

   // Set is OR-ed in after the clear so a re-issue on the commit edge stays pending
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clr) | w_set;
      end
   end

   assign o_pending = r_pending;
   assign o_hazard  = r_pending[i_src_rs] | r_pending[i_src_rt];
endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester register write-back arbiter: B has priority, A is force-granted
// after MAX_WAIT refusals; one-cycle registered write stage plus scoreboard.
module reg_write_arbiter
   import reg_arb_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic               Clock,
   input  logic               Reset_n,
   reg_write_arbiter_if.slave bus
);
   localparam logic [AGE_W-1:0] MAX_WAIT_L = AGE_W'(MAX_WAIT);

   logic [AGE_W-1:0]      r_age_p0;
   grant_e                w_grant;
   logic                  w_force;
   logic                  r_vld_p1;
   logic [REG_ADDR_W-1:0] r_rd_p1;
   logic [DATA_W-1:0]     r_wdata_p1;
   logic [NUM_REGS-1:0]   w_pending;
   logic                  w_hazard;

   // Stage p0: grant decision, combinational from the valids and the age counter
   always_comb begin
      w_force = bus.A_Valid && (r_age_p0 == MAX_WAIT_L);
      w_grant = GRANT_NONE;
      if (!Reset_n) begin
         w_grant = GRANT_NONE;
      end else if (w_force) begin
         w_grant = GRANT_A;
      end else if (bus.B_Valid) begin
         w_grant = GRANT_B;
      end else if (bus.A_Valid) begin
         w_grant = GRANT_A;
      end
   end

   assign bus.A_Ready = (w_grant == GRANT_A);
   assign bus.B_Ready = (w_grant == GRANT_B);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_age_p0 <= '0;
      end else if (!bus.A_Valid || bus.A_Ready) begin
         r_age_p0 <= '0;
      end else if (r_age_p0 != MAX_WAIT_L) begin
         r_age_p0 <= r_age_p0 + AGE_W'(1);
      end
   end

   // Stage p1: registered register-file write; address/data hold when idle
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_vld_p1   <= 1'b0;
         r_rd_p1    <= '0;
         r_wdata_p1 <= '0;
      end else begin
         r_vld_p1 <= (w_grant != GRANT_NONE);
         if (w_grant == GRANT_A) begin
            r_rd_p1    <= bus.A_RD;
            r_wdata_p1 <= bus.A_Data;
         end else if (w_grant == GRANT_B) begin
            r_rd_p1    <= bus.B_RD;
            r_wdata_p1 <= bus.B_Data;
         end
      end
   end

   assign bus.RegWrite  = r_vld_p1;
   assign bus.RD        = r_rd_p1;
   assign bus.WriteData = r_wdata_p1;

   reg_scoreboard u_scoreboard (
      .i_clk     (Clock),
      .i_rst_n   (Reset_n),
      .i_set_vld (bus.Issue_Valid),
      .i_set_rd  (bus.Issue_RD),
      .i_clr_vld (r_vld_p1),
      .i_clr_rd  (r_rd_p1),
      .i_src_rs  (bus.Src_RS),
      .i_src_rt  (bus.Src_RT),
      .o_pending (w_pending),
      .o_hazard  (w_hazard)
   );

   assign bus.Hazard = w_hazard;
   assign bus.Busy   = (|w_pending) || r_vld_p1 || bus.A_Valid || bus.B_Valid;
endmodule
